// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared owner encodings and default sizes for the data-memory arbiter
//
// Purpose: single place for the owner codes reported on the owner output and
// the default geometry of the 16x16 data memory and the aging threshold.
// Ports: none (package).

package dmem_arb_pkg;

  localparam int DEF_ADDR_W  = 4;
  localparam int DEF_DATA_W  = 16;
  localparam int DEF_AGE_MAX = 7;
  localparam int DEF_AGE_W   = 3;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_LD   = 2'd2,
    OWN_DSP  = 2'd3
  } owner_e;

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// rtl/dmem_port_arbiter_if.sv - requester and memory bus bundle for the data-memory arbiter
//
// Purpose: groups the three requester handshakes, the shared read-return bus
// and the single-port memory bus into one interface.
// Modports:
//   slave  - the arbiter: takes requests and mem_rdata, drives grants,
//            rvalids, rdata, owner and the memory strobe/address/data.
//   master - the surroundings (CPU MEM stage, loader, scanner, memory):
//            the mirror image of slave.
// Signals:
//   cpu_req/cpu_we/cpu_addr/cpu_wdata -> cpu_gnt, cpu_rvalid
//   ld_req/ld_addr/ld_wdata           -> ld_gnt
//   dsp_req/dsp_addr                  -> dsp_gnt, dsp_rvalid
//   rdata, owner, mem_en/mem_we/mem_addr/mem_wdata out, mem_rdata in

interface dmem_port_arbiter_if
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) ();

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_rvalid;

  logic              ld_req;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_wdata;
  logic              ld_gnt;

  logic              dsp_req;
  logic [ADDR_W-1:0] dsp_addr;
  logic              dsp_gnt;
  logic              dsp_rvalid;

  logic [DATA_W-1:0] rdata;
  logic [1:0]        owner;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_rvalid,
    input  ld_req, ld_addr, ld_wdata,
    output ld_gnt,
    input  dsp_req, dsp_addr,
    output dsp_gnt, dsp_rvalid,
    output rdata, owner,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_rvalid,
    output ld_req, ld_addr, ld_wdata,
    input  ld_gnt,
    output dsp_req, dsp_addr,
    input  dsp_gnt, dsp_rvalid,
    input  rdata, owner,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/req_age_ctr.sv
// rtl/req_age_ctr.sv - saturating wait counter with aged flag for one low-priority requester
//
// Purpose: counts the cycles a requester has been waiting with req high and
// no grant; raises aged once the count reaches AGE_MAX so the arbiter can
// promote it above the CPU.
// Ports:
//   Clk   in  clock
//   Clr_n in  synchronous active-low reset
//   req   in  requester's req line
//   gnt   in  requester's grant this cycle
//   aged  out count has reached AGE_MAX

module req_age_ctr
  import dmem_arb_pkg::*;
#(
  parameter int AGE_MAX = DEF_AGE_MAX,
  parameter int AGE_W   = DEF_AGE_W
) (
  input  logic Clk,
  input  logic Clr_n,
  input  logic req,
  input  logic gnt,
  output logic aged
);

  localparam logic [AGE_W-1:0] AGE_SAT = AGE_W'(AGE_MAX);

  logic [AGE_W-1:0] age_q;
  logic [AGE_W-1:0] age_d;

  // A dropped request forfeits its accumulated wait; a grant restarts it.
  always_comb begin
    age_d = age_q;
    if (!req || gnt) begin
      age_d = '0;
    end else if (age_q != AGE_SAT) begin
      age_d = age_q + AGE_W'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (!Clr_n) begin
      age_q <= '0;
    end else begin
      age_q <= age_d;
    end
  end

  assign aged = (age_q == AGE_SAT);

endmodule

// File: rtl/dmem_port_arbiter.sv
// rtl/dmem_port_arbiter.sv - three-way fixed-priority arbiter with aging for the shared data memory
//
// Purpose: shares one single-port synchronous memory between the CPU MEM
// stage, the switch/button loader (writes) and the display scanner (reads).
// Order, highest first: aged dsp, aged ld, cpu, ld, dsp. Each read grant is
// tagged and returned as an rvalid pulse to its requester one cycle later.
// Ports:
//   Clk   in  clock, all state on the rising edge
//   Clr_n in  synchronous active-low reset
//   bus   slave modport of dmem_port_arbiter_if (requests, grants,
//         rvalids, rdata, owner, memory bus)

module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int AGE_MAX = DEF_AGE_MAX,
  parameter int AGE_W   = DEF_AGE_W
) (
  input  logic                 Clk,
  input  logic                 Clr_n,
  dmem_port_arbiter_if.slave   bus
);

  owner_e            own;
  logic              ld_aged;
  logic              dsp_aged;

  logic              mem_en_s;
  logic              mem_we_s;
  logic [ADDR_W-1:0] mem_addr_s;
  logic [DATA_W-1:0] mem_wdata_s;

  logic              cpu_rvalid_q;
  logic              cpu_rvalid_d;
  logic              dsp_rvalid_q;
  logic              dsp_rvalid_d;

  req_age_ctr #(
    .AGE_MAX (AGE_MAX),
    .AGE_W   (AGE_W)
  ) u_ld_age (
    .Clk   (Clk),
    .Clr_n (Clr_n),
    .req   (bus.ld_req),
    .gnt   (bus.ld_gnt),
    .aged  (ld_aged)
  );

  req_age_ctr #(
    .AGE_MAX (AGE_MAX),
    .AGE_W   (AGE_W)
  ) u_dsp_age (
    .Clk   (Clk),
    .Clr_n (Clr_n),
    .req   (bus.dsp_req),
    .gnt   (bus.dsp_gnt),
    .aged  (dsp_aged)
  );

  // Winner selection. The aged flags lag req by a cycle, so they only count
  // while the requester is still asserting req. Grants are suppressed
  // during reset so nothing issued in a reset cycle can return an rvalid.
  always_comb begin
    own = OWN_NONE;
    if (Clr_n) begin
      if (bus.dsp_req && dsp_aged) begin
        own = OWN_DSP;
      end else if (bus.ld_req && ld_aged) begin
        own = OWN_LD;
      end else if (bus.cpu_req) begin
        own = OWN_CPU;
      end else if (bus.ld_req) begin
        own = OWN_LD;
      end else if (bus.dsp_req) begin
        own = OWN_DSP;
      end
    end
  end

  // Memory bus mux. The loader is write-only and the scanner read-only, so
  // their direction is forced; an idle bus is driven to all zeros.
  always_comb begin
    mem_en_s    = 1'b0;
    mem_we_s    = 1'b0;
    mem_addr_s  = '0;
    mem_wdata_s = '0;
    case (own)
      OWN_CPU: begin
        mem_en_s    = 1'b1;
        mem_we_s    = bus.cpu_we;
        mem_addr_s  = bus.cpu_addr;
        mem_wdata_s = bus.cpu_wdata;
      end
      OWN_LD: begin
        mem_en_s    = 1'b1;
        mem_we_s    = 1'b1;
        mem_addr_s  = bus.ld_addr;
        mem_wdata_s = bus.ld_wdata;
      end
      OWN_DSP: begin
        mem_en_s    = 1'b1;
        mem_we_s    = 1'b0;
        mem_addr_s  = bus.dsp_addr;
        mem_wdata_s = '0;
      end
      default: begin
      end
    endcase
  end

  // Read tags: the memory answers one cycle after the strobe, so the
  // requester that owned a read this cycle sees rvalid next cycle.
  always_comb begin
    cpu_rvalid_d = (own == OWN_CPU) && !bus.cpu_we;
    dsp_rvalid_d = (own == OWN_DSP);
  end

  always_ff @(posedge Clk) begin
    if (!Clr_n) begin
      cpu_rvalid_q <= 1'b0;
      dsp_rvalid_q <= 1'b0;
    end else begin
      cpu_rvalid_q <= cpu_rvalid_d;
      dsp_rvalid_q <= dsp_rvalid_d;
    end
  end

  assign bus.cpu_gnt    = (own == OWN_CPU);
  assign bus.ld_gnt     = (own == OWN_LD);
  assign bus.dsp_gnt    = (own == OWN_DSP);
  assign bus.owner      = own;

  assign bus.mem_en     = mem_en_s;
  assign bus.mem_we     = mem_we_s;
  assign bus.mem_addr   = mem_addr_s;
  assign bus.mem_wdata  = mem_wdata_s;

  assign bus.cpu_rvalid = cpu_rvalid_q;
  assign bus.dsp_rvalid = dsp_rvalid_q;
  assign bus.rdata      = bus.mem_rdata;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb/tb_dmem_port_arbiter.sv - directed vector and sequence bench for dmem_port_arbiter
module tb_dmem_port_arbiter;
  import dmem_arb_pkg::*;

  logic Clk = 1'b0;
  logic Clr_n = 1'b0;
  always #5 Clk = ~Clk;

  dmem_port_arbiter_if #(.ADDR_W(4), .DATA_W(16)) bus ();

  dmem_port_arbiter #(
    .ADDR_W(4), .DATA_W(16), .AGE_MAX(7), .AGE_W(3)
  ) dut (
    .Clk   (Clk),
    .Clr_n (Clr_n),
    .bus   (bus)
  );

  // 16x16 single-port memory, 1-cycle synchronous read
  logic [15:0] mem [16];
  always @(posedge Clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata <= mem[bus.mem_addr];
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic idle();
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.ld_req = 1'b0; bus.ld_addr = '0; bus.ld_wdata = '0;
    bus.dsp_req = 1'b0; bus.dsp_addr = '0;
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  typedef struct {
    logic cr; logic cw; logic [3:0] ca; logic [15:0] cd;
    logic lr; logic [3:0] la; logic [15:0] ld;
    logic dr; logic [3:0] da;
    logic [1:0] own; logic en; logic we; logic [3:0] ma; logic [15:0] md;
    logic crv; logic drv; logic chkrd; logic [15:0] rd;
  } vec_t;

  vec_t vt [11];

  // CPU held busy; ld rises at cycle 0, dsp at cycle dsp_start; each drops after its grant
  task automatic run_contend(input int dsp_start, output int g_l, output int g_d,
                             output int n_multi, output int ld_age_at_g);
    g_l = -1; g_d = -1; n_multi = 0; ld_age_at_g = -1;
    bus.ld_addr = 4'h8; bus.ld_wdata = 16'h00C8; bus.dsp_addr = 4'h8;
    for (int k = 0; k < 20; k++) begin
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 4'(k);
      if (k == 0) bus.ld_req = 1'b1;
      if (k == dsp_start) bus.dsp_req = 1'b1;
      @(negedge Clk);
      if (32'(bus.cpu_gnt) + 32'(bus.ld_gnt) + 32'(bus.dsp_gnt) > 1) n_multi++;
      if (bus.ld_gnt && g_l < 0) begin
        g_l = k;
        ld_age_at_g = int'(dut.u_ld_age.age_q);
      end
      if (bus.dsp_gnt && g_d < 0) g_d = k;
      step();
      if (g_l >= 0) bus.ld_req = 1'b0;
      if (g_d >= 0) bus.dsp_req = 1'b0;
      if (g_l >= 0 && g_d >= 0) break;
    end
    idle();
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int g, g_l, g_d, n_multi, la;

    vt[0]  = '{1'b1,1'b1,4'h3,16'h00A5, 1'b0,4'h9,16'h7777, 1'b0,4'h6, 2'd1,1'b1,1'b1,4'h3,16'h00A5, 1'b0,1'b0,1'b0,16'h0000};
    vt[1]  = '{1'b1,1'b0,4'h3,16'h0000, 1'b0,4'h0,16'h0000, 1'b0,4'h0, 2'd1,1'b1,1'b0,4'h3,16'h0000, 1'b0,1'b0,1'b0,16'h0000};
    vt[2]  = '{1'b0,1'b1,4'hC,16'hBEEF, 1'b0,4'hB,16'h4444, 1'b0,4'hD, 2'd0,1'b0,1'b0,4'h0,16'h0000, 1'b1,1'b0,1'b1,16'h00A5};
    vt[3]  = '{1'b0,1'b0,4'h0,16'hFFFF, 1'b1,4'h5,16'h1234, 1'b0,4'h0, 2'd2,1'b1,1'b1,4'h5,16'h1234, 1'b0,1'b0,1'b0,16'h0000};
    vt[4]  = '{1'b0,1'b1,4'h0,16'hFFFF, 1'b0,4'h0,16'h5555, 1'b1,4'h5, 2'd3,1'b1,1'b0,4'h5,16'h0000, 1'b0,1'b0,1'b0,16'h0000};
    vt[5]  = '{1'b0,1'b0,4'h0,16'h0000, 1'b0,4'h0,16'h0000, 1'b0,4'h0, 2'd0,1'b0,1'b0,4'h0,16'h0000, 1'b0,1'b1,1'b1,16'h1234};
    vt[6]  = '{1'b1,1'b0,4'h5,16'h0000, 1'b0,4'h0,16'h0000, 1'b1,4'h3, 2'd1,1'b1,1'b0,4'h5,16'h0000, 1'b0,1'b0,1'b0,16'h0000};
    vt[7]  = '{1'b0,1'b0,4'h0,16'h0000, 1'b0,4'h0,16'h0000, 1'b1,4'h3, 2'd3,1'b1,1'b0,4'h3,16'h0000, 1'b1,1'b0,1'b1,16'h1234};
    vt[8]  = '{1'b0,1'b0,4'h0,16'h0000, 1'b1,4'h7,16'h0BEE, 1'b1,4'h3, 2'd2,1'b1,1'b1,4'h7,16'h0BEE, 1'b0,1'b1,1'b1,16'h00A5};
    vt[9]  = '{1'b0,1'b0,4'h0,16'h0000, 1'b0,4'h0,16'h0000, 1'b1,4'h7, 2'd3,1'b1,1'b0,4'h7,16'h0000, 1'b0,1'b0,1'b0,16'h0000};
    vt[10] = '{1'b0,1'b0,4'h0,16'h0000, 1'b0,4'h0,16'h0000, 1'b0,4'h0, 2'd0,1'b0,1'b0,4'h0,16'h0000, 1'b0,1'b1,1'b1,16'h0BEE};

    // Reset state, with every requester asking
    idle();
    bus.cpu_req = 1'b1; bus.ld_req = 1'b1; bus.dsp_req = 1'b1;
    Clr_n = 1'b0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    chk("rst.owner", 32'(bus.owner), 0);
    chk("rst.gnts", {bus.cpu_gnt, bus.ld_gnt, bus.dsp_gnt}, 0);
    chk("rst.mem_en", 32'(bus.mem_en), 0);
    chk("rst.mem_we", 32'(bus.mem_we), 0);
    chk("rst.rvalids", {bus.cpu_rvalid, bus.dsp_rvalid}, 0);
    chk("rst.ages", {dut.u_ld_age.age_q, dut.u_dsp_age.age_q}, 0);
    step();
    Clr_n = 1'b1;
    idle();

    // Table-driven single-cycle vectors
    for (int i = 0; i < 11; i++) begin
      bus.cpu_req = vt[i].cr; bus.cpu_we = vt[i].cw; bus.cpu_addr = vt[i].ca; bus.cpu_wdata = vt[i].cd;
      bus.ld_req = vt[i].lr; bus.ld_addr = vt[i].la; bus.ld_wdata = vt[i].ld;
      bus.dsp_req = vt[i].dr; bus.dsp_addr = vt[i].da;
      @(negedge Clk);
      chk($sformatf("vec%0d.owner", i), 32'(bus.owner), 32'(vt[i].own));
      chk($sformatf("vec%0d.gnts", i), {bus.cpu_gnt, bus.ld_gnt, bus.dsp_gnt},
          {vt[i].own == 2'd1, vt[i].own == 2'd2, vt[i].own == 2'd3});
      chk($sformatf("vec%0d.mem_en", i), 32'(bus.mem_en), 32'(vt[i].en));
      chk($sformatf("vec%0d.mem_we", i), 32'(bus.mem_we), 32'(vt[i].we));
      chk($sformatf("vec%0d.mem_addr", i), 32'(bus.mem_addr), 32'(vt[i].ma));
      chk($sformatf("vec%0d.mem_wdata", i), 32'(bus.mem_wdata), 32'(vt[i].md));
      chk($sformatf("vec%0d.cpu_rvalid", i), 32'(bus.cpu_rvalid), 32'(vt[i].crv));
      chk($sformatf("vec%0d.dsp_rvalid", i), 32'(bus.dsp_rvalid), 32'(vt[i].drv));
      if (vt[i].chkrd) chk($sformatf("vec%0d.rdata", i), 32'(bus.rdata), 32'(vt[i].rd));
      step();
    end
    idle();

    // Loader write under continuous CPU reads: served in its 8th cycle of request
    g = -1;
    bus.ld_req = 1'b1; bus.ld_addr = 4'h5; bus.ld_wdata = 16'h1234;
    for (int k = 0; k < 16; k++) begin
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 4'(k);
      @(negedge Clk);
      if (bus.ld_gnt && g < 0) begin
        g = k;
        chk("ld_aged.mem_addr", 32'(bus.mem_addr), 5);
        chk("ld_aged.mem_we", 32'(bus.mem_we), 1);
      end
      step();
      if (g >= 0) break;
    end
    chk("ld_aged.grant_cycle", g, 7);
    idle();
    bus.dsp_req = 1'b1; bus.dsp_addr = 4'h5;
    @(negedge Clk);
    chk("ld_aged.dsp_gnt", 32'(bus.dsp_gnt), 1);
    step();
    idle();
    @(negedge Clk);
    chk("ld_aged.dsp_rvalid", 32'(bus.dsp_rvalid), 1);
    chk("ld_aged.rdata", 32'(bus.rdata), 16'h1234);
    step();

    // All three busy, ld one cycle ahead of dsp
    run_contend(1, g_l, g_d, n_multi, la);
    chk("contend.ld_cycle", g_l, 7);
    chk("contend.dsp_cycle", g_d, 8);
    chk("contend.ld_before_dsp", 32'(g_l >= 0 && g_l < g_d), 1);
    chk("contend.multi_gnt", n_multi, 0);

    // Aged tie: dsp wins, ld keeps AGE_MAX and wins next cycle
    run_contend(0, g_l, g_d, n_multi, la);
    chk("tie.dsp_cycle", g_d, 7);
    chk("tie.ld_cycle", g_l, 8);
    chk("tie.ld_age_at_gnt", la, 7);
    chk("tie.multi_gnt", n_multi, 0);

    // Loader fills 0..9 with 9..0, scanner reads back-to-back
    for (int j = 0; j < 10; j++) begin
      bus.ld_req = 1'b1; bus.ld_addr = 4'(j); bus.ld_wdata = 16'(9 - j);
      @(negedge Clk);
      chk($sformatf("fill%0d.ld_gnt", j), 32'(bus.ld_gnt), 1);
      step();
    end
    idle();
    for (int j = 0; j <= 10; j++) begin
      bus.dsp_req = (j < 10); bus.dsp_addr = 4'(j % 10);
      @(negedge Clk);
      if (j > 0) begin
        chk($sformatf("scan%0d.dsp_rvalid", j - 1), 32'(bus.dsp_rvalid), 1);
        chk($sformatf("scan%0d.rdata", j - 1), 32'(bus.rdata), 32'(10 - j));
      end
      step();
    end
    idle();

    // Reset coincident with a scanner read
    for (int k = 0; k < 3; k++) begin
      bus.cpu_req = 1'b1; bus.ld_req = 1'b1; bus.dsp_req = 1'b1; bus.dsp_addr = 4'h2;
      step();
    end
    bus.cpu_req = 1'b0; bus.ld_req = 1'b0;
    Clr_n = 1'b0;
    @(negedge Clk);
    chk("rstmid.dsp_age_before", 32'(dut.u_dsp_age.age_q), 3);
    chk("rstmid.dsp_gnt", 32'(bus.dsp_gnt), 0);
    chk("rstmid.owner", 32'(bus.owner), 0);
    chk("rstmid.mem_en", 32'(bus.mem_en), 0);
    step();
    Clr_n = 1'b1;
    idle();
    @(negedge Clk);
    chk("rstmid.dsp_rvalid", 32'(bus.dsp_rvalid), 0);
    chk("rstmid.ages", {dut.u_ld_age.age_q, dut.u_dsp_age.age_q}, 0);
    chk("rstmid.owner_after", 32'(bus.owner), 0);
    step();

    // Loader gives up after 3 cycles under CPU load
    for (int k = 0; k < 3; k++) begin
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 4'(k);
      bus.ld_req = 1'b1; bus.ld_addr = 4'hE; bus.ld_wdata = 16'hDEAD;
      @(negedge Clk);
      chk($sformatf("abandon%0d.ld_gnt", k), 32'(bus.ld_gnt), 0);
      chk($sformatf("abandon%0d.mem_we", k), 32'(bus.mem_we), 0);
      step();
    end
    bus.ld_req = 1'b0;
    @(negedge Clk);
    chk("abandon.age_at_drop", 32'(dut.u_ld_age.age_q), 3);
    chk("abandon.mem_we_drop", 32'(bus.mem_we), 0);
    step();
    idle();
    @(negedge Clk);
    chk("abandon.age_cleared", 32'(dut.u_ld_age.age_q), 0);
    chk("abandon.no_write", 32'(bus.mem_we), 0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
